tick_rate_controller: RTL and testbench
=======================================

// Module: tick_rate_controller
// PURPOSE
//  Configures and sequences the divided clock/tick timebase used by the design.
//  Divide ratio and tick count are loaded over a valid/ready config port.
//  Software-style start/stop control produces a square clkOUT and a 1-cycle tick strobe.
//  Runs either continuously or as a one-shot burst of N ticks.
//  Sits between control logic (FSM, buttons) and the consumers of the slow clock enable.
// PARAMETERS
//  DIV_W        32        width of divide-ratio register
//  CNT_W        16        width of tick-count register
//  DEFAULT_DIV  25000000  div_reg value after reset (half-period = DEFAULT_DIV+1 cycles)
// PORTS
//  clkIN      in   1      system clock; all logic on posedge
//  rst        in   1      reset; synchronous, active-high
//  cfg_valid  in   1      config offer
//  cfg_ready  out  1      config accept; high only in IDLE
//  cfg_div    in   DIV_W  half-period minus one, in clkIN cycles
//  cfg_n      in   CNT_W  tick count for one-shot; 0 = continuous
//  start      in   1      1-cycle request to begin running
//  stop       in   1      1-cycle request to abort running
//  clkOUT     out  1      divided square output
//  tick       out  1      1-cycle strobe on every clkOUT edge
//  busy       out  1      high while in RUN
//  done       out  1      1-cycle strobe when a one-shot burst completes
// BEHAVIOUR
//  Reset: state=IDLE, div_reg=DEFAULT_DIV, n_reg=0, cnt=0, tcnt=0;
//   clkOUT=0, tick=0, done=0, busy=0, cfg_ready=1. Reset mid-RUN aborts in one edge.
//  Config: cfg_valid&&cfg_ready at an edge loads div_reg<=cfg_div and n_reg<=cfg_n.
//   No load in RUN; cfg_ready=0 in RUN; cfg_valid in RUN is held off, not dropped.
//   Config loaded on the same edge as start is used by that run.
//  FSM: IDLE, RUN. All outputs registered.
//   IDLE: start&&!stop -> RUN; cnt<=0, tcnt<=0, clkOUT<=0.
//     start&&stop together in IDLE: stop wins, stay IDLE.
//   RUN: cnt increments each cycle. When cnt==div_reg: cnt<=0, tick<=1, tcnt<=tcnt+1.
//     Otherwise tick<=0.
//     On a tick edge, clkOUT toggles unless it is the final one-shot tick.
//     Final tick: n_reg!=0 && tcnt+1==n_reg. On it: tick<=1, done<=1, clkOUT<=0, ->IDLE.
//     stop in RUN -> IDLE next edge; clkOUT<=0, tick<=0, done stays 0.
//     stop beats a coincident tick; start in RUN is ignored.
//  Timing: with start sampled at edge E, ticks occur at edges E+(div_reg+1)*k, k>=1.
//   Tick period = div_reg+1 cycles; clkOUT period = 2*(div_reg+1).
//   div_reg=0: tick every cycle and clkOUT toggles every cycle.
//  Widths: cnt is DIV_W bits and never exceeds div_reg (no wrap).
//   tcnt is CNT_W bits and only used when n_reg!=0.
//   Continuous mode never asserts done.
//  busy==(state==RUN); cfg_ready==!busy.
// TESTING
//  1 Reset: rst high 2 cycles -> clkOUT=0, tick=0, done=0, busy=0, cfg_ready=1.
//    Then start with no cfg -> first tick after 25000001 cycles (spot-check counter).
//  2 Continuous: cfg_div=3, cfg_n=0, start at edge 0 -> tick at edges 4,8,12,16.
//    clkOUT=1 after edge 4, 0 after edge 8; done never asserts.
//  3 One-shot: cfg_div=1, cfg_n=3, start at edge 0 -> ticks at edges 2,4,6.
//    done=1 and busy=0 after edge 6; clkOUT 1,0,then forced 0.
//  4 Stop: cfg_div=3, run, assert stop on the edge-8 tick cycle -> IDLE.
//    clkOUT=0, no tick, no done. Also start+stop together in IDLE -> stays IDLE.
//  5 Config handshake: cfg_valid with cfg_div=5 while busy -> cfg_ready=0, div unchanged.
//    After stop it is accepted; next run ticks every 6 cycles.
//  6 Edge ratio: cfg_div=0, cfg_n=2, start -> ticks on two consecutive edges.
//    done on the second tick; also rst asserted mid-RUN -> all outputs 0 next edge.

Source files
------------

// File: rtl/tick_rate_controller.sv
// Divided clock / tick timebase with a valid/ready config port.
// Ports: clkIN, rst, cfg_valid/ready/div/n, start, stop, clkOUT, tick, busy, done.
module tick_rate_controller #(
  parameter int          DIV_W       = 32,
  parameter int          CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 25000000
) (
  input  logic             clkIN,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_n,
  input  logic             start,
  input  logic             stop,
  output logic             clkOUT,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] tcnt_inc;
  logic             clk_d, tick_d, done_d;

  assign tcnt_inc  = tcnt_q + CNT_W'(1);
  assign busy      = (state_q == RUN);
  assign cfg_ready = ~busy;

  always_ff @(posedge clkIN) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= DIV_W'(DEFAULT_DIV);
      n_q     <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      clkOUT  <= 1'b0;
      tick    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      clkOUT  <= clk_d;
      tick    <= tick_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    clk_d   = clkOUT;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_d = 1'b0;
        if (cfg_valid) begin
          div_d = cfg_div;
          n_d   = cfg_n;
        end
        if (start && !stop) begin
          state_d = RUN;
          cnt_d   = '0;
          tcnt_d  = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          clk_d   = 1'b0;
        end else if (cnt_q == div_q) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          tcnt_d = tcnt_inc;
          // last burst tick parks clkOUT low
          if (n_q != '0 && tcnt_inc == n_q) begin
            done_d  = 1'b1;
            clk_d   = 1'b0;
            state_d = IDLE;
          end else begin
            clk_d = ~clkOUT;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tick_rate_controller.sv
// Bench for tick_rate_controller: directed steps plus random
// stimulus checked against an elapsed-time reference model.
module tb_tick_rate_controller;

  localparam int          DIV_W = 32;
  localparam int          CNT_W = 16;
  localparam int unsigned DEFD  = 25000000;

  logic             clkIN = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [CNT_W-1:0] cfg_n = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             clkOUT, tick, busy, done;

  int checks = 0;
  int errors = 0;

  bit     m_run, m_clk, m_tick, m_done;
  longint m_el, m_div, m_n;

  tick_rate_controller #(
    .DIV_W(DIV_W), .CNT_W(CNT_W), .DEFAULT_DIV(DEFD)
  ) dut (
    .clkIN(clkIN), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_n(cfg_n),
    .start(start), .stop(stop),
    .clkOUT(clkOUT), .tick(tick),
    .busy(busy), .done(done)
  );

  always #5 clkIN = ~clkIN;

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  // Ticks fall at elapsed = k*(div+1); clkOUT is the
  // parity of k, except the final burst tick forces 0.
  task automatic model(input bit cv, input longint cd,
                       input longint cn, input bit st,
                       input bit sp, input bit rs);
    longint k;
    if (rs) begin
      m_run = 0; m_div = DEFD; m_n = 0;
      m_clk = 0; m_tick = 0; m_done = 0; m_el = 0;
    end else if (!m_run) begin
      m_tick = 0; m_done = 0; m_clk = 0;
      if (cv) begin m_div = cd; m_n = cn; end
      if (st && !sp) begin m_run = 1; m_el = 0; end
    end else if (sp) begin
      m_run = 0; m_clk = 0; m_tick = 0; m_done = 0;
    end else begin
      m_el++;
      m_tick = 0; m_done = 0;
      if (m_el % (m_div + 1) == 0) begin
        k = m_el / (m_div + 1);
        m_tick = 1;
        if (m_n != 0 && k == m_n) begin
          m_done = 1; m_clk = 0; m_run = 0;
        end else begin
          m_clk = k[0];
        end
      end
    end
  endtask

  task automatic step(input bit cv = 0, input int cd = 0,
                      input int cn = 0, input bit st = 0,
                      input bit sp = 0, input bit rs = 0);
    cfg_valid = cv;
    cfg_div   = DIV_W'(cd);
    cfg_n     = CNT_W'(cn);
    start     = st;
    stop      = sp;
    rst       = rs;
    @(posedge clkIN);
    model(cv, cd, cn, st, sp, rs);
    #1;
    chk("clkOUT", clkOUT, m_clk);
    chk("tick", tick, m_tick);
    chk("done", done, m_done);
    chk("busy", busy, m_run);
    chk("cfg_ready", cfg_ready, !m_run);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // 1: reset, default divider spot check
    step(.rs(1));
    step(.rs(1));
    step(.st(1));
    idle(2000);
    chk("cnt_spot", longint'(dut.cnt_q), 2000);
    step(.sp(1));
    idle(2);
    // 2: continuous, div=3
    step(.cv(1), .cd(3), .cn(0), .st(1));
    idle(17);
    step(.sp(1));
    // 3: one-shot, div=1 n=3
    step(.cv(1), .cd(1), .cn(3), .st(1));
    idle(8);
    // 4: stop on tick cycle, start+stop in IDLE
    step(.cv(1), .cd(3), .cn(0), .st(1));
    idle(7);
    step(.sp(1));
    idle(2);
    step(.st(1), .sp(1));
    idle(2);
    // 5: config held off while busy
    step(.cv(1), .cd(3), .cn(0), .st(1));
    for (int i = 0; i < 3; i++) step(.cv(1), .cd(5));
    step(.cv(1), .cd(5), .sp(1));
    step(.cv(1), .cd(5));
    step(.st(1));
    idle(13);
    step(.sp(1));
    // 6: div=0 burst, then reset mid-run
    step(.cv(1), .cd(0), .cn(2), .st(1));
    idle(3);
    step(.cv(1), .cd(2), .cn(0), .st(1));
    idle(4);
    step(.rs(1));
    idle(1);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step(.cv($urandom_range(0, 3) == 0),
           .cd(int'($urandom_range(0, 6))),
           .cn(int'($urandom_range(0, 4))),
           .st($urandom_range(0, 15) == 0),
           .sp($urandom_range(0, 40) == 0),
           .rs($urandom_range(0, 300) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
